// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default ring parameters and the pointwise-multiplier state encoding.
package ntt_pkg;

    localparam int          NTT_N          = 256;
    localparam int          NTT_WIDTH      = 32;
    localparam int          NTT_ADDR_WIDTH = 8;
    localparam int unsigned NTT_Q          = 8380417;
    // Multiplicative inverse of NTT_N modulo NTT_Q, applied by the inverse NTT stage.
    localparam int unsigned NTT_N_INV      = 8347681;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        KICK,
        WAIT_INTT,
        DONE
    } pm_state_t;

endpackage

// File: rtl/coeff_ram.sv
// Coefficient buffer: port B is the write (load) port, port A a registered read port.
module coeff_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [WIDTH-1:0]      wdata_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    output logic [WIDTH-1:0]      rdata_a_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store a coefficient when enabled.
    // NOTE: the array has no reset branch, so it maps onto block RAM; contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (we_b_i) begin
            mem_q[addr_b_i] <= wdata_b_i;
        end
    end

    // Read port: one cycle of registered read latency.
    always_ff @(posedge clk) begin
        rdata_a_o <= mem_q[addr_a_i];
    end

endmodule

// File: rtl/mod_mult.sv
// Combinational modular multiplier: full 2*WIDTH product reduced into [0, Q) for any inputs.
module mod_mult #(
    parameter int          WIDTH          = 32,
    parameter int unsigned Q              = 8380417,
    parameter int          REDUCTION_TYPE = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] Q_W = PW'(Q);

    logic [PW-1:0] prod;

    assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    generate
        if (REDUCTION_TYPE == 1) begin : g_barrett
            // mu = floor(2^PW / Q); the quotient estimate is at most one short, so one correction suffices.
            localparam logic [PW-1:0] MU = PW'(((2 * PW)'(1) << PW) / (2 * PW)'(Q));

            logic [2*PW-1:0] qmul;
            logic [PW-1:0]   qhat;
            logic [PW-1:0]   rem;

            // Barrett reduction of the double-width product.
            // NOTE: every variable gets a value before any condition, so no latch can be inferred.
            always_comb begin
                qmul = {{PW{1'b0}}, prod} * {{PW{1'b0}}, MU};
                qhat = PW'(qmul >> PW);
                rem  = prod - qhat * Q_W;
                if (rem >= Q_W) begin
                    rem = rem - Q_W;
                end
            end

            assign p_o = WIDTH'(rem);
        end else begin : g_direct
            // Operands arrive in normal (not Montgomery) form, so type 2 also uses the direct reduction.
            assign p_o = WIDTH'(prod % Q_W);
        end
    endgenerate

endmodule

// File: rtl/ntt_pointwise_mul.sv
// NTT-domain pointwise multiplier: C[i] = A[i]*B[i] mod Q streamed into the inverse NTT, which is then kicked.
module ntt_pointwise_mul
    import ntt_pkg::*;
#(
    parameter int          N              = NTT_N,
    parameter int          WIDTH          = NTT_WIDTH,
    parameter int unsigned Q              = NTT_Q,
    parameter int          ADDR_WIDTH     = NTT_ADDR_WIDTH,
    parameter int          REDUCTION_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WIDTH-1:0]      load_data,
    output logic                  intt_load_coeff,
    output logic [ADDR_WIDTH-1:0] intt_load_addr,
    output logic [WIDTH-1:0]      intt_load_data,
    output logic                  intt_start,
    input  logic                  intt_done
);

    // Counter is one bit wider than the address so it can sit at N once all reads are issued.
    localparam logic [ADDR_WIDTH:0]   CNT_END   = (ADDR_WIDTH + 1)'(N);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    pm_state_t             state_q;
    logic [ADDR_WIDTH:0]   k_q;
    logic [ADDR_WIDTH:0]   k_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  intt_start_q;

    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [WIDTH-1:0]      out_data_q;

    logic                  load_ok;
    logic                  issue;
    logic                  last_emitted;
    logic [WIDTH-1:0]      a_rdata;
    logic [WIDTH-1:0]      b_rdata;
    logic [WIDTH-1:0]      product;

    // Operand buffers only accept loads while no multiply is in flight.
    assign load_ok      = (state_q == IDLE) || (state_q == DONE);
    assign issue        = (state_q == MULT) && (k_q < CNT_END);
    assign k_d          = k_q + 1'b1;
    assign last_emitted = out_valid_q && (out_addr_q == LAST_ADDR);

    coeff_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (N)
    ) u_ram_a (
        .clk       (clk),
        .we_b_i    (load_a && load_ok),
        .addr_b_i  (load_addr),
        .wdata_b_i (load_data),
        .addr_a_i  (k_q[ADDR_WIDTH-1:0]),
        .rdata_a_o (a_rdata)
    );

    coeff_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (N)
    ) u_ram_b (
        .clk       (clk),
        .we_b_i    (load_b && load_ok),
        .addr_b_i  (load_addr),
        .wdata_b_i (load_data),
        .addr_a_i  (k_q[ADDR_WIDTH-1:0]),
        .rdata_a_o (b_rdata)
    );

    mod_mult #(
        .WIDTH          (WIDTH),
        .Q              (Q),
        .REDUCTION_TYPE (REDUCTION_TYPE)
    ) u_mod_mult (
        .a_i (a_rdata),
        .b_i (b_rdata),
        .p_o (product)
    );

    // Control FSM with registered busy/done/intt_start, plus the read-address counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            intt_start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    k_q <= '0;
                    if (start) begin
                        state_q <= MULT;
                        busy_q  <= 1'b1;
                    end
                end
                MULT: begin
                    if (k_q < CNT_END) begin
                        k_q <= k_d;
                    end
                    if (last_emitted) begin
                        state_q      <= KICK;
                        intt_start_q <= 1'b1;
                    end
                end
                KICK: begin
                    state_q <= WAIT_INTT;
                end
                WAIT_INTT: begin
                    if (intt_done) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        intt_start_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    k_q          <= '0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    intt_start_q <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage valid/address pipeline matching the RAM read and the product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            rd_valid_q  <= issue;
            rd_addr_q   <= k_q[ADDR_WIDTH-1:0];
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_addr_q <= rd_addr_q;
                out_data_q <= product;
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign intt_start      = intt_start_q;
    assign intt_load_coeff = out_valid_q;
    assign intt_load_addr  = out_addr_q;
    assign intt_load_data  = out_data_q;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Directed bench for ntt_pointwise_mul with a scoreboard of expected inverse-NTT writes and a stub inverse NTT.
module tb_ntt_pointwise_mul;
    import ntt_pkg::*;

    localparam int unsigned Q = NTT_Q;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        load_a;
    logic        load_b;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        intt_load_coeff;
    logic [7:0]  intt_load_addr;
    logic [31:0] intt_load_data;
    logic        intt_start;
    logic        intt_done;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] ra [256];
    logic [31:0] rb [256];

    ntt_pointwise_mul dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .load_a          (load_a),
        .load_b          (load_b),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .intt_load_coeff (intt_load_coeff),
        .intt_load_addr  (intt_load_addr),
        .intt_load_data  (intt_load_data),
        .intt_start      (intt_start),
        .intt_done       (intt_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mod_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(p % 64'(Q));
    endfunction

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_t e;
        e.addr = 8'(addr);
        e.data = data;
        sb.push_back(e);
    endtask

    // Drive one load beat; it is written on the following rising edge.
    task automatic load_word(input bit wa, input bit wb, input int addr, input logic [31:0] d);
        @(negedge clk);
        load_a    = wa;
        load_b    = wb;
        load_addr = 8'(addr);
        load_data = d;
    endtask

    task automatic load_end();
        @(negedge clk);
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    // Start pulse sampled by IDLE; returns just after the edge that enters MULT (cycle T0).
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Observe cycles T0..T0+N+2 mid-cycle; optionally disturb at one cycle, or stop early after a given cycle.
    task automatic watch_mult(input int disturb_at, input int abort_at);
        exp_t e;
        for (int c = 0; c <= 258; c++) begin
            @(negedge clk);
            check("busy_in_run", busy, 1);
            check("done_in_run", done, 0);
            check("intt_start_timing", intt_start, 64'(c == 258));
            check("load_coeff_timing", intt_load_coeff, 64'(c >= 2 && c <= 257));
            if (intt_load_coeff) begin
                check("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("load_addr", intt_load_addr, e.addr);
                    check("load_data", intt_load_data, e.data);
                    check("data_below_q", 64'(intt_load_data < Q), 1);
                end
            end
            if (c == disturb_at) begin
                start     = 1'b1;
                load_a    = 1'b1;
                load_b    = 1'b1;
                load_addr = 8'd200;
                load_data = 32'hDEAD;
                intt_done = 1'b1;
            end else if (c == disturb_at + 1) begin
                start     = 1'b0;
                load_a    = 1'b0;
                load_b    = 1'b0;
                load_addr = '0;
                load_data = '0;
                intt_done = 1'b0;
            end
            if (c == abort_at) begin
                return;
            end
        end
        check("sb_drained", 64'(sb.size()), 0);
    endtask

    // Stub inverse NTT: raise done 'delay' cycles after KICK, hold it until intt_start drops.
    task automatic finish_intt(input int delay, input bit hold_start);
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk);
            if (d == 1) begin
                check("wait_intt_start", intt_start, 1);
                check("wait_busy", busy, 1);
                check("wait_no_coeff", intt_load_coeff, 0);
            end
            if (d == delay) begin
                intt_done = 1'b1;
            end
        end
        @(negedge clk);
        check("done_flag", done, 1);
        check("done_busy", busy, 0);
        check("done_intt_start", intt_start, 0);
        intt_done = 1'b0;
        if (hold_start) begin
            start = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("done_held_by_start", done, 1);
                check("no_restart_from_done", busy, 0);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_addr = '0;
        load_data = '0;
        intt_done = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coeff", intt_load_coeff, 0);
        check("rst_addr", intt_load_addr, 0);
        check("rst_data", intt_load_data, 0);
        check("rst_intt_start", intt_start, 0);
        rst = 1'b0;

        // 1: all-ones via joint A/B load; disturbance at cycle 100; slow inverse NTT; start held in DONE.
        for (int i = 0; i < 256; i++) load_word(1'b1, 1'b1, i, 32'd1);
        load_end();
        for (int i = 0; i < 256; i++) push_exp(i, 32'd1);
        do_start();
        watch_mult(100, -1);
        finish_intt(4352, 1'b1);

        // 2: A[i]=i, B[i]=2 via separate loads.
        for (int i = 0; i < 256; i++) load_word(1'b1, 1'b0, i, 32'(i));
        for (int i = 0; i < 256; i++) load_word(1'b0, 1'b1, i, 32'd2);
        load_end();
        for (int i = 0; i < 256; i++) push_exp(i, 32'(2 * i));
        do_start();
        watch_mult(-1, -1);
        finish_intt(3, 1'b0);

        // 6: reset at the k=100 write, then a complete rerun on the same operands.
        for (int i = 0; i < 256; i++) push_exp(i, 32'(2 * i));
        do_start();
        watch_mult(-1, 102);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_coeff", intt_load_coeff, 0);
        check("midrst_addr", intt_load_addr, 0);
        check("midrst_data", intt_load_data, 0);
        check("midrst_intt_start", intt_start, 0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 256; i++) push_exp(i, 32'(2 * i));
        do_start();
        watch_mult(-1, -1);
        finish_intt(3, 1'b0);

        // 3: Q-1 squared, N*N_INV, and an unreduced all-ones input.
        for (int i = 0; i < 256; i++) load_word(1'b1, 1'b1, i, 32'(Q - 1));
        load_word(1'b1, 1'b0, 0, 32'd256);
        load_word(1'b0, 1'b1, 0, 32'd8347681);
        load_word(1'b1, 1'b0, 1, 32'hFFFF_FFFF);
        load_word(1'b0, 1'b1, 1, 32'd1);
        load_end();
        push_exp(0, 32'd1);
        push_exp(1, 32'd4193791);
        for (int i = 2; i < 256; i++) push_exp(i, 32'd1);
        do_start();
        watch_mult(-1, -1);
        finish_intt(3, 1'b0);

        // Random full-width operands against the reference product.
        for (int i = 0; i < 256; i++) begin
            ra[i] = $urandom();
            rb[i] = $urandom();
        end
        for (int i = 0; i < 256; i++) load_word(1'b1, 1'b0, i, ra[i]);
        for (int i = 0; i < 256; i++) load_word(1'b0, 1'b1, i, rb[i]);
        load_end();
        for (int i = 0; i < 256; i++) push_exp(i, mod_ref(ra[i], rb[i]));
        do_start();
        watch_mult(-1, -1);
        finish_intt(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
